tennis_game_fsm: RTL and testbench
==================================

// Module: tennis_game_fsm
// PURPOSE
//  Two-player LED tennis game core. Sits directly downstream of the two push-button
//  debouncers and consumes their one-cycle PB_down pulses as hit_l / hit_r.
//  Moves a one-hot ball across NUM_LEDS LEDs and judges returns, early swings and misses.
//  Keeps per-player scores and declares a winner. Drives the LED bar and score displays.
// PARAMETERS
//  NUM_LEDS        16          LED bar width; ball positions 0 (left end) .. NUM_LEDS-1 (right end)
//  STEP_CYCLES     12_500_000  clk cycles per ball step (125 ms @ 100 MHz)
//  MIN_STEP_CYCLES 3_125_000   floor for step period (used only with TENNIS_SPEEDUP_EN)
//  PAUSE_STEPS     8           step periods held in POINT state
//  SCORE_W         4           score counter width
//  WIN_SCORE       7           points to win; must be < 2**SCORE_W
// PORTS
//  clk       in   1         system clock
//  reset     in   1         synchronous, active-high reset
//  hit_l     in   1         left player hit, 1-cycle pulse, clk-synchronous (debouncer PB_down)
//  hit_r     in   1         right player hit, 1-cycle pulse, clk-synchronous
//  leds      out  NUM_LEDS  LED bar
//  score_l   out  SCORE_W   left score
//  score_r   out  SCORE_W   right score
//  point_l   out  1         1-cycle pulse: point awarded to left
//  point_r   out  1         1-cycle pulse: point awarded to right
//  game_over out  1         high while in GAME_OVER
// BEHAVIOUR
//  - Reset: state=SERVE, server=left, pos=0, scores=0, step cnt=0, point_l/point_r=0, game_over=0, leds=1.
//  - All state, pos, score and pulse registers update on posedge clk.
//    leds/game_over are decodes of registered state, valid the cycle after the causing edge.
//  - Step timer: counts 0..period-1 and asserts step when cnt==period-1.
//    Runs only in RALLY/POINT; cleared on entry to RALLY/POINT and on every successful return.
//  - SERVE: ball parked at server's end (leds=1<<pos). Server's hit -> RALLY, heading to opponent.
//    Opponent's hit ignored.
//  - RALLY: receiver = player the ball is heading toward.
//    . receiver hit, pos==receiver end -> return: direction flips, timer cleared, pos unchanged this cycle.
//    . receiver hit, pos!=receiver end -> fault (early swing): point to other player -> POINT.
//    . step, pos==receiver end, no hit -> miss: point to other player -> POINT.
//    . step otherwise -> pos moves one LED toward receiver.
//    . Hitter's (non-receiver's) pulse always ignored; with both pulses in one cycle only the receiver's counts.
//    . Receiver hit and step in the same cycle: the hit is evaluated; the step is discarded.
//  - Point award: winner score += 1 (saturating); point_x pulses for the entry cycle.
//    server := point loser.
//  - POINT: leds all ones for PAUSE_STEPS steps.
//    Then GAME_OVER if either score==WIN_SCORE, else SERVE (pos = new server's end).
//  - GAME_OVER: leds = lower half lit if left won, upper half if right won; scores hold.
//    Any hit pulse -> scores cleared, server=left, SERVE.
//  - Reset mid-operation overrides everything in the same edge (reset values above).
// CONFIGURATION
//  TENNIS_SPEEDUP_EN defined:
//   - period := STEP_CYCLES on every entry to SERVE.
//   - Each successful return: period := max(period - (period>>3), MIN_STEP_CYCLES).
//   - Period register width = $clog2(STEP_CYCLES+1).
//  Undefined: period fixed at STEP_CYCLES; MIN_STEP_CYCLES unused.
// TESTING  (NUM_LEDS=8, STEP_CYCLES=4, PAUSE_STEPS=2, WIN_SCORE=3 unless noted)
//  1 reset; hit_r pulse -> leds=8'h01, scores 0, no state change, no point pulse
//  2 hit_l, no further hits:
//    - pos advances 1..7, one step per 4 cycles.
//    - Step at pos7 -> point_l 1 cycle, score_l=1, leds=8'hFF for 8 cycles, then leds=8'h80 (right serves).
//  3 rally: hit_r at pos7 -> ball returns to pos6 after 4 cycles.
//    Next rally: hit_r at pos5 -> fault, point_l, score_l++.
//  4 hit_r same cycle as step at pos7 -> return, no point. Pulse hit_l mid-flight -> ignored.
//  5 left wins 3 points -> game_over=1, leds=8'h0F; hit_r -> scores 0, leds=8'h01.
//    reset asserted mid-rally -> reset values next cycle.
//  6 STEP_CYCLES=64, MIN=16, two returns:
//    - With TENNIS_SPEEDUP_EN: period 64->56->49; back to 64 after next serve.
//    - Without macro: period stays 64.

Source files
------------

// File: rtl/tennis_game_fsm.sv
// Two-player LED tennis core: serves, rallies, returns, faults/misses, scoring and game over.
// Optional macro TENNIS_SPEEDUP_EN shortens the ball step period on every successful return.
//
// state     | meaning
// S_SERVE   | ball parked at server's end, waiting for server's hit
// S_RALLY   | ball in flight toward the receiver
// S_POINT   | point just awarded, all LEDs lit for PAUSE_STEPS steps
// S_OVER    | a player reached WIN_SCORE, winner's half of the bar lit
module tennis_game_fsm #(
  parameter int NUM_LEDS        = 16,
  parameter int STEP_CYCLES     = 12_500_000,
  parameter int MIN_STEP_CYCLES = 3_125_000,
  parameter int PAUSE_STEPS     = 8,
  parameter int SCORE_W         = 4,
  parameter int WIN_SCORE       = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hit_l,
  input  logic                hit_r,
  output logic [NUM_LEDS-1:0] leds,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r,
  output logic                point_l,
  output logic                point_r,
  output logic                game_over
);

  localparam int PW   = $clog2(STEP_CYCLES + 1);
  localparam int POSW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int PSW  = $clog2(PAUSE_STEPS + 1);

  localparam logic [POSW-1:0]     LAST    = POSW'(NUM_LEDS - 1);
  localparam logic [PW-1:0]       STEP_P  = PW'(STEP_CYCLES);
  localparam logic [PSW-1:0]      PAUSE_L = PSW'(PAUSE_STEPS - 1);
  localparam logic [SCORE_W-1:0]  WIN     = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0]  SMAX    = '1;
  localparam logic [NUM_LEDS-1:0] LO_MASK = {NUM_LEDS{1'b1}} >> (NUM_LEDS - NUM_LEDS / 2);

  if (WIN_SCORE >= (1 << SCORE_W) || MIN_STEP_CYCLES > STEP_CYCLES) begin : g_bad_params
    $error("tennis_game_fsm: WIN_SCORE or MIN_STEP_CYCLES out of range");
  end

  typedef enum logic [1:0] {S_SERVE, S_RALLY, S_POINT, S_OVER} state_t;

  state_t             state_q, state_d;
  logic               server_q, server_d;   // 1 = right player serves
  logic               dir_q, dir_d;         // 1 = ball heading right
  logic [POSW-1:0]    pos_q, pos_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [PW-1:0]      cnt_q, cnt_d;
  logic [PSW-1:0]     pause_q, pause_d;
  logic               point_l_q, point_l_d, point_r_q, point_r_d;
  logic [PW-1:0]      period;

  logic step, recv_hit, srv_hit, at_end;
  logic ret, serve_entry, award, award_left;

`ifdef TENNIS_SPEEDUP_EN
  localparam logic [PW-1:0] MIN_P = PW'(MIN_STEP_CYCLES);
  logic [PW-1:0] period_q, period_d, period_fast;

  assign period = period_q;

  always_comb begin
    period_fast = period_q - (period_q >> 3);
    if (period_fast < MIN_P) period_fast = MIN_P;
    period_d = period_q;
    if (serve_entry)  period_d = STEP_P;
    else if (ret)     period_d = period_fast;
  end
`else
  assign period = STEP_P;
`endif

  assign step     = (state_q == S_RALLY || state_q == S_POINT) && (cnt_q == period - 1'b1);
  assign recv_hit = dir_q ? hit_r : hit_l;
  assign srv_hit  = server_q ? hit_r : hit_l;
  assign at_end   = dir_q ? (pos_q == LAST) : (pos_q == '0);

  always_comb begin
    state_d     = state_q;
    server_d    = server_q;
    dir_d       = dir_q;
    pos_d       = pos_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    pause_d     = pause_q;
    point_l_d   = 1'b0;
    point_r_d   = 1'b0;
    ret         = 1'b0;
    serve_entry = 1'b0;
    award       = 1'b0;
    award_left  = 1'b0;
    cnt_d       = '0;
    if (state_q == S_RALLY || state_q == S_POINT) cnt_d = step ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_SERVE: begin
        if (srv_hit) begin
          state_d = S_RALLY;
          dir_d   = ~server_q;
          cnt_d   = '0;
        end
      end
      S_RALLY: begin
        // a receiver hit takes priority over a coincident step
        if (recv_hit) begin
          if (at_end) begin
            ret   = 1'b1;
            dir_d = ~dir_q;
          end else begin
            award      = 1'b1;
            award_left = dir_q;
          end
        end else if (step) begin
          if (at_end) begin
            award      = 1'b1;
            award_left = dir_q;
          end else begin
            pos_d = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
          end
        end
      end
      S_POINT: begin
        if (step) begin
          if (pause_q == PAUSE_L) begin
            if (score_l_q == WIN || score_r_q == WIN) begin
              state_d = S_OVER;
            end else begin
              state_d     = S_SERVE;
              serve_entry = 1'b1;
            end
          end else begin
            pause_d = pause_q + 1'b1;
          end
        end
      end
      S_OVER: begin
        if (hit_l || hit_r) begin
          score_l_d   = '0;
          score_r_d   = '0;
          server_d    = 1'b0;
          state_d     = S_SERVE;
          serve_entry = 1'b1;
        end
      end
      default: state_d = S_SERVE;
    endcase

    if (award) begin
      state_d = S_POINT;
      cnt_d   = '0;
      pause_d = '0;
      if (award_left) begin
        score_l_d = (score_l_q == SMAX) ? SMAX : score_l_q + 1'b1;
        point_l_d = 1'b1;
        server_d  = 1'b1;
      end else begin
        score_r_d = (score_r_q == SMAX) ? SMAX : score_r_q + 1'b1;
        point_r_d = 1'b1;
        server_d  = 1'b0;
      end
    end
    if (ret)         cnt_d = '0;
    if (serve_entry) pos_d = server_d ? LAST : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_SERVE;
      server_q  <= 1'b0;
      dir_q     <= 1'b1;
      pos_q     <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      cnt_q     <= '0;
      pause_q   <= '0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
`ifdef TENNIS_SPEEDUP_EN
      period_q  <= STEP_P;
`endif
    end else begin
      state_q   <= state_d;
      server_q  <= server_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      cnt_q     <= cnt_d;
      pause_q   <= pause_d;
      point_l_q <= point_l_d;
      point_r_q <= point_r_d;
`ifdef TENNIS_SPEEDUP_EN
      period_q  <= period_d;
`endif
    end
  end

  always_comb begin
    leds = '0;
    case (state_q)
      S_SERVE, S_RALLY: leds = NUM_LEDS'(1) << pos_q;
      S_POINT:          leds = '1;
      S_OVER:           leds = (score_l_q == WIN) ? LO_MASK : ~LO_MASK;
      default:          leds = '0;
    endcase
  end

  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign point_l   = point_l_q;
  assign point_r   = point_r_q;
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_tennis_game_fsm.sv
// Bench for tennis_game_fsm: directed scenarios, randomized play against a flight-time model,
// and a slow-period instance that measures step intervals across returns and serves.
module tb_tennis_game_fsm;
  localparam int N = 8, SC = 4, PS = 2, WS = 3, SW = 4;
  localparam int SC2 = 64, MIN2 = 16;

  logic clk = 1'b0;
  logic reset, hit_l, hit_r;
  logic [N-1:0] leds;
  logic [SW-1:0] score_l, score_r;
  logic point_l, point_r, game_over;

  logic reset2, hit_l2, hit_r2;
  logic [N-1:0] leds2;
  logic [SW-1:0] score_l2, score_r2;
  logic point_l2, point_r2, game_over2;

  always #5 clk = ~clk;

  tennis_game_fsm #(.NUM_LEDS(N), .STEP_CYCLES(SC), .MIN_STEP_CYCLES(1), .PAUSE_STEPS(PS),
                    .SCORE_W(SW), .WIN_SCORE(WS)) dut (
    .clk(clk), .reset(reset), .hit_l(hit_l), .hit_r(hit_r), .leds(leds),
    .score_l(score_l), .score_r(score_r), .point_l(point_l), .point_r(point_r),
    .game_over(game_over));

  tennis_game_fsm #(.NUM_LEDS(N), .STEP_CYCLES(SC2), .MIN_STEP_CYCLES(MIN2), .PAUSE_STEPS(PS),
                    .SCORE_W(SW), .WIN_SCORE(WS)) dut2 (
    .clk(clk), .reset(reset2), .hit_l(hit_l2), .hit_r(hit_r2), .leds(leds2),
    .score_l(score_l2), .score_r(score_r2), .point_l(point_l2), .point_r(point_r2),
    .game_over(game_over2));

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: phase 0 serve, 1 rally, 2 point pause, 3 game over.
  // In flight, position follows from the flight start and the cycles elapsed since then.
  int m_phase, m_server, m_from, m_dir, m_t, m_sl, m_sr, m_pl, m_pr, m_P;

  function automatic int m_pos();
    return m_from + m_dir * (m_t / m_P);
  endfunction

  function automatic int m_recv_end();
    return (m_dir > 0) ? N - 1 : 0;
  endfunction

  function automatic logic [N-1:0] m_leds();
    logic [N-1:0] one = 1;
    case (m_phase)
      0: return one << ((m_server != 0) ? N - 1 : 0);
      1: return one << m_pos();
      2: return '1;
      default: return (m_sl == WS) ? 8'h0F : 8'hF0;
    endcase
  endfunction

  task automatic m_award(input bit left_wins);
    if (left_wins) begin m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_pl = 1; m_server = 1; end
    else begin m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_pr = 1; m_server = 0; end
    m_phase = 2;
    m_t = 0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_server = 0; m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0;
      m_P = SC; m_t = 0; m_from = 0; m_dir = 1;
    end else begin
      m_pl = 0; m_pr = 0;
      case (m_phase)
        0: if ((m_server == 0 && hit_l) || (m_server == 1 && hit_r)) begin
             m_phase = 1; m_from = (m_server != 0) ? N - 1 : 0;
             m_dir = (m_server != 0) ? -1 : 1; m_t = 0;
           end
        1: begin
             if ((m_dir > 0) ? hit_r : hit_l) begin
               if (m_pos() == m_recv_end()) begin
                 m_from = m_pos(); m_dir = -m_dir; m_t = 0;
`ifdef TENNIS_SPEEDUP_EN
                 m_P = (m_P - m_P / 8 < 1) ? 1 : m_P - m_P / 8;
`endif
               end else m_award(m_dir > 0);
             end else if ((m_t + 1) % m_P == 0 && m_pos() == m_recv_end()) m_award(m_dir > 0);
             else m_t++;
           end
        2: if (m_t + 1 == PS * m_P) begin
             if (m_sl == WS || m_sr == WS) m_phase = 3;
             else begin m_phase = 0; m_P = SC; end
           end else m_t++;
        default: if (hit_l || hit_r) begin
             m_sl = 0; m_sr = 0; m_server = 0; m_phase = 0; m_P = SC;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("leds", int'(leds), int'(m_leds()));
      check("score_l", int'(score_l), m_sl);
      check("score_r", int'(score_r), m_sr);
      check("point_l", int'(point_l), m_pl);
      check("point_r", int'(point_r), m_pr);
      check("game_over", int'(game_over), int'(m_phase == 3));
    end
  end

  task automatic tick(input logic hl, input logic hr);
    hit_l = hl; hit_r = hr;
    @(negedge clk);
    hit_l = 1'b0; hit_r = 1'b0;
  endtask

  task automatic tick2(input logic hl, input logic hr);
    hit_l2 = hl; hit_r2 = hr;
    @(negedge clk);
    hit_l2 = 1'b0; hit_r2 = 1'b0;
  endtask

  task automatic wait_leds(input logic [N-1:0] v, input int budget, input string name);
    int n = 0;
    while (leds !== v && n < budget) begin tick(0, 0); n++; end
    check(name, int'(leds), int'(v));
  endtask

  task automatic count_until(input logic [N-1:0] v, input int budget, output int n);
    n = 0;
    while (leds !== v && n < budget) begin tick(0, 0); n++; end
  endtask

  task automatic wait2(input logic [N-1:0] v, input int budget, input string name);
    int n = 0;
    while (leds2 !== v && n < budget) begin tick2(0, 0); n++; end
    check(name, int'(leds2), int'(v));
  endtask

  task automatic measure2(output int n);
    logic [N-1:0] start;
    start = leds2;
    n = 0;
    while (leds2 === start && n < 300) begin tick2(0, 0); n++; end
  endtask

  function automatic int next_period(input int p);
`ifdef TENNIS_SPEEDUP_EN
    return (p - p / 8 < MIN2) ? MIN2 : p - p / 8;
`else
    return p;
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p1, p2;
    logic hl, hr, rs;
    reset = 1; hit_l = 0; hit_r = 0; reset2 = 1; hit_l2 = 0; hit_r2 = 0;
    repeat (2) @(negedge clk);
    reset = 0; reset2 = 0; chk_en = 1'b1;

    // reset state and ignored opponent serve
    check("rst_leds", int'(leds), 8'h01);
    check("rst_game_over", int'(game_over), 0);
    tick(0, 1);
    check("serve_ignore_leds", int'(leds), 8'h01);
    check("serve_ignore_pt", int'(point_r), 0);

    // serve left, ball walks right and is missed
    tick(1, 0);
    count_until(8'h02, 20, n);
    check("step_interval", n, SC);
    wait_leds(8'h80, 40, "reach_pos7");
    n = 0;
    while (point_l !== 1'b1 && n < 10) begin tick(0, 0); n++; end
    check("miss_point_l", int'(point_l), 1);
    check("miss_score_l", int'(score_l), 1);
    check("miss_leds", int'(leds), 8'hFF);
    count_until(8'h80, 20, n);
    check("pause_len", n, PS * SC);

    // right serves, left returns, mid-flight hitter pulse ignored
    tick(0, 1);
    wait_leds(8'h01, 40, "reach_pos0");
    tick(1, 0);
    check("return_no_point", int'(point_r), 0);
    count_until(8'h02, 20, n);
    check("return_interval", n, SC);
    tick(1, 0);
    check("hitter_ignored", int'(point_l | point_r), 0);

    // return on the very cycle of the step at the end
    wait_leds(8'h80, 40, "reach_pos7b");
    repeat (SC - 1) tick(0, 0);
    tick(0, 1);
    check("hit_on_step_no_pt", int'(point_l), 0);
    check("hit_on_step_leds", int'(leds), 8'h80);
    count_until(8'h40, 20, n);
    check("hit_on_step_interval", n, SC);

    // early swing by right at pos5
    wait_leds(8'h01, 40, "reach_pos0b");
    tick(1, 0);
    wait_leds(8'h20, 40, "reach_pos5");
    tick(0, 1);
    check("fault_point_l", int'(point_l), 1);
    check("fault_score_l", int'(score_l), 2);

    // third point wins the game for left
    wait_leds(8'h80, 20, "serve_right");
    tick(0, 1);
    wait_leds(8'h01, 40, "reach_pos0c");
    tick(1, 0);
    wait_leds(8'h04, 40, "reach_pos2");
    tick(0, 1);
    n = 0;
    while (game_over !== 1'b1 && n < 20) begin tick(0, 0); n++; end
    check("game_over", int'(game_over), 1);
    check("game_over_leds", int'(leds), 8'h0F);
    check("game_over_score", int'(score_l), WS);
    tick(0, 1);
    check("restart_leds", int'(leds), 8'h01);
    check("restart_score_l", int'(score_l), 0);
    check("restart_game_over", int'(game_over), 0);

    // both pulses at once: only the receiver counts
    tick(1, 0);
    wait_leds(8'h80, 40, "reach_pos7c");
    tick(1, 1);
    check("both_hits_no_pt", int'(point_l | point_r), 0);
    wait_leds(8'h04, 40, "reach_pos2b");

    // reset mid-rally
    reset = 1; tick(0, 0); reset = 0;
    check("midreset_leds", int'(leds), 8'h01);
    check("midreset_scores", int'(score_l) + int'(score_r), 0);

    // randomized play
    for (int c = 0; c < 5000; c++) begin
      hl = 0; hr = 0;
      if (m_phase == 1 && m_pos() == m_recv_end() && $urandom_range(2) == 0) begin
        if (m_dir > 0) hr = 1; else hl = 1;
      end else begin
        hl = ($urandom_range(15) == 0);
        hr = ($urandom_range(15) == 0);
      end
      rs = ($urandom_range(799) == 0);
      reset = rs;
      tick(hl, hr);
      reset = 0;
    end

    // period evolution on the slow instance
    p1 = next_period(SC2);
    p2 = next_period(p1);
    tick2(1, 0);
    measure2(n);
    check("p_serve", n, SC2);
    wait2(8'h80, 1000, "p_reach_pos7");
    tick2(0, 1);
    measure2(n);
    check("p_after_ret1", n, p1);
    wait2(8'h01, 1000, "p_reach_pos0");
    tick2(1, 0);
    measure2(n);
    check("p_after_ret2", n, p2);
    n = 0;
    while (point_l2 !== 1'b1 && n < 1000) begin tick2(0, 0); n++; end
    check("p_miss_point_l", int'(point_l2), 1);
    wait2(8'h80, 400, "p_serve_right");
    tick2(0, 1);
    measure2(n);
    check("p_after_serve", n, SC2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
